// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encoding, helpers
//                deriving the bit and half-bit periods from the clock and
//                baud rate, and the baud counter width shared by the
//                transmitter and receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver states. PARITY is only visited when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // System clocks per line bit (integer division).
    function automatic int calc_baud_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // System clocks from the start-bit edge to the middle of the start bit.
    function automatic int calc_half_period(input int clk_freq, input int baud_rate);
        return calc_baud_period(clk_freq, baud_rate) / 2;
    endfunction

    // Width of a counter that runs 0..BAUD_PERIOD-1; never narrower than 1.
    function automatic int calc_cnt_width(input int clk_freq, input int baud_rate);
        int bp;
        bp = calc_baud_period(clk_freq, baud_rate);
        return (bp > 1) ? $clog2(bp) : 1;
    endfunction

    // Counter width at the default 50 MHz / 115200 operating point.
    localparam int c_CNT_W = calc_cnt_width(50_000_000, 115_200);

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous serial line plus
//                a previous-value flop for falling-edge detection. All flops
//                reset to 1 so an idle-high line produces no edge after reset.
//  Ports       : clk       in  system clock
//                rst       in  asynchronous active-high reset
//                i_rx      in  raw serial line
//                o_rx_sync out synchronized line
//                o_fall    out high while synced line is 0 and was 1 before
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_sync = r_sync;
    assign o_fall    = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_rtl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_rtl
//  Description : UART receiver. Oversamples rx with the system clock, detects
//                the start bit on a synced falling edge, samples WIDTH data
//                bits LSB-first at mid-bit, checks the stop bit and presents
//                each good word with a one-cycle data_valid strobe.
//  Build macro : UART_RX_PARITY_EN - adds an even-parity bit after the data
//                bits, the PARITY state and the parity_err output.
//  Ports       : clk        in  system clock, rising edge
//                rst        in  asynchronous active-high reset
//                rx         in  serial line, idle high
//                data       out last correctly received word
//                data_valid out one-cycle pulse, data updated
//                rx_busy    out start detection until return to IDLE
//                frame_err  out one-cycle pulse, stop bit sampled low
//                parity_err out one-cycle pulse, parity mismatch (macro only)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_rtl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             rx_busy,
    output logic             frame_err
`ifdef UART_RX_PARITY_EN
   ,output logic             parity_err
`endif
);

    localparam int c_BAUD       = calc_baud_period(CLK_FREQ, BAUD_RATE);
    localparam int c_HALF       = calc_half_period(CLK_FREQ, BAUD_RATE);
    localparam int c_BAUD_CNT_W = calc_cnt_width(CLK_FREQ, BAUD_RATE);
    localparam int c_BIT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_BAUD_CNT_W-1:0] c_BAUD_LAST = c_BAUD_CNT_W'(c_BAUD - 1);
    localparam logic [c_BAUD_CNT_W-1:0] c_HALF_LAST = c_BAUD_CNT_W'(c_HALF - 1);
    localparam logic [c_BIT_W-1:0]      c_BIT_LAST  = c_BIT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic w_rx_s;
    logic w_rx_fall;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_rx      (rx),
        .o_rx_sync (w_rx_s),
        .o_fall    (w_rx_fall)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    rx_state_t               r_state;
    logic [c_BAUD_CNT_W-1:0] r_cnt;
    logic [c_BIT_W-1:0]      r_bit;
    logic [WIDTH-1:0]        r_shift;
    logic [WIDTH-1:0]        r_data;
    logic                    r_valid;
    logic                    r_ferr;
    logic                    r_busy;

    rx_state_t               w_state_next;
    logic [c_BAUD_CNT_W-1:0] w_cnt_next;
    logic [c_BIT_W-1:0]      w_bit_next;
    logic [WIDTH-1:0]        w_shift_next;
    logic [WIDTH-1:0]        w_data_next;
    logic                    w_valid_next;
    logic                    w_ferr_next;
    logic                    w_busy_next;
    logic                    w_frame_done;
    logic                    w_par_bad;

`ifdef UART_RX_PARITY_EN
    // Parity verdict is held from the PARITY sample until the stop bit.
    logic r_par_bad;
    logic r_perr;
    logic w_par_bad_next;
    logic w_perr_next;

    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_ferr    <= w_ferr_next;
            r_busy    <= w_busy_next;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_next;
            r_perr    <= w_perr_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + 1'b1;
        w_bit_next     = r_bit;
        w_shift_next   = r_shift;
        w_data_next    = r_data;
        w_valid_next   = 1'b0;
        w_ferr_next    = 1'b0;
        w_frame_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
        w_perr_next    = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                // Only an edge starts a frame, so a line stuck low (break)
                // must return high before the next frame can begin.
                w_cnt_next = '0;
                w_bit_next = '0;
`ifdef UART_RX_PARITY_EN
                w_par_bad_next = 1'b0;
`endif
                if (w_rx_fall) begin
                    w_state_next = START;
                end
            end

            START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_next = '0;
                    // A line back high at mid-start-bit was a glitch.
                    w_state_next = w_rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (r_cnt == c_BAUD_LAST) begin
                    w_cnt_next   = '0;
                    // LSB arrives first, so shift in from the top.
                    w_shift_next = {w_rx_s, r_shift[WIDTH-1:1]};
                    if (r_bit == c_BIT_LAST) begin
                        w_bit_next = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == c_BAUD_LAST) begin
                    w_cnt_next     = '0;
                    // Even parity: the parity bit plus data bits hold an
                    // even count of ones.
                    w_par_bad_next = w_rx_s ^ (^r_shift);
                    w_state_next   = STOP;
                end
            end
`endif

            STOP: begin
                if (r_cnt == c_BAUD_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                    w_frame_done = 1'b1;
                    w_ferr_next  = ~w_rx_s;
                    w_valid_next = w_rx_s & ~w_par_bad;
`ifdef UART_RX_PARITY_EN
                    w_perr_next  = w_par_bad;
`endif
                    if (w_rx_s && !w_par_bad) begin
                        w_data_next = r_shift;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Busy stays up through the result pulse and drops one cycle later.
        w_busy_next = (w_state_next != IDLE) | w_frame_done;
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign rx_busy    = r_busy;
    assign frame_err  = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_rtl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_rtl
//  Description : Self-checking bench for uart_rx_rtl. The stimulus process
//                serializes frames onto rx and pushes the expected outcome
//                of each frame into a queue; an independent monitor pops an
//                entry whenever the receiver pulses a result and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_rtl;

    localparam int c_CLK_FREQ  = 50_000_000;
    localparam int c_BAUD_RATE = 115200;
    localparam int c_W         = 8;
    localparam int c_BAUD      = c_CLK_FREQ / c_BAUD_RATE;   // 434
    localparam int c_HALF      = c_BAUD / 2;                 // 217
`ifdef UART_RX_PARITY_EN
    localparam int c_LAT = c_HALF + (c_W + 2) * c_BAUD;
`else
    localparam int c_LAT = c_HALF + (c_W + 1) * c_BAUD;      // 4123
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx  = 1'b1;
    logic [c_W-1:0] data;
    logic           data_valid;
    logic           rx_busy;
    logic           frame_err;
    logic           perr;

    always #5 clk = ~clk;

    uart_rx_rtl #(
        .CLK_FREQ  (c_CLK_FREQ),
        .BAUD_RATE (c_BAUD_RATE),
        .WIDTH     (c_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err)
`ifdef UART_RX_PARITY_EN
       ,.parity_err (perr)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    typedef struct packed {
        logic           v;
        logic           fe;
        logic           pe;
        logic [c_W-1:0] d;
    } exp_t;

    exp_t           exp_q[$];
    logic [c_W-1:0] last_good = '0;
    int             n_checks  = 0;
    int             n_pass    = 0;
    int             cyc       = 0;
    int             busy_rise = 0;
    int             last_busy_len = -1;
    logic           prev_busy  = 1'b0;
    logic           after_pulse = 1'b0;

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Reference model: outcome of one frame from its line-level contents.
    task automatic model_push(input logic [c_W-1:0] d, input logic stop_b,
                              input logic par_b);
        exp_t e;
        logic par_bad;
`ifdef UART_RX_PARITY_EN
        par_bad = (par_b != logic'($countones(d) % 2));
`else
        par_bad = 1'b0;
        if (par_b) par_bad = 1'b0;
`endif
        e.v  = stop_b && !par_bad;
        e.fe = !stop_b;
        e.pe = par_bad;
        e.d  = e.v ? d : last_good;
        if (e.v) last_good = d;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [c_W-1:0] d, input logic stop_b,
                              input logic par_b);
        model_push(d, stop_b, par_b);
        hold(1'b0, c_BAUD);
        for (int i = 0; i < c_W; i++) hold(d[i], c_BAUD);
`ifdef UART_RX_PARITY_EN
        hold(par_b, c_BAUD);
`endif
        hold(stop_b, c_BAUD);
    endtask

    function automatic logic good_par(input logic [c_W-1:0] d);
        return logic'($countones(d) % 2);
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rx_busy && !prev_busy) busy_rise = cyc;
        if (!rx_busy && prev_busy) last_busy_len = cyc - busy_rise;
        if (after_pulse) begin
            check("after_pulse_quiet", !rx_busy && !data_valid && !frame_err && !perr,
                  {29'd0, rx_busy, data_valid, frame_err}, 32'd0);
            after_pulse = 1'b0;
        end else if (data_valid || frame_err || perr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1'b0,
                      {29'd0, data_valid, frame_err, perr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {data_valid, frame_err, perr} == {e.v, e.fe, e.pe},
                      {29'd0, data_valid, frame_err, perr}, {29'd0, e.v, e.fe, e.pe});
                check("data", data == e.d, 32'(data), 32'(e.d));
                check("latency", (cyc - busy_rise) == c_LAT,
                      32'(cyc - busy_rise), 32'(c_LAT));
            end
            after_pulse = 1'b1;
        end
        prev_busy = rx_busy;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [c_W-1:0] d;
        logic           sb;
        logic           pb;
        int             n;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_outputs", {data, data_valid, rx_busy, frame_err, perr} == '0,
              32'({data, data_valid, rx_busy, frame_err, perr}), 32'd0);
        rst = 1'b0;
        hold(1'b1, 20);
        check("post_reset_idle", {data, rx_busy} == '0, 32'({data, rx_busy}), 32'd0);

        // Single clean frame, then two frames with no idle gap.
        send_frame(8'h42, 1'b1, good_par(8'h42));
        hold(1'b1, 50);
        send_frame(8'h42, 1'b1, good_par(8'h42));
        send_frame(8'h6F, 1'b1, good_par(8'h6F));
        hold(1'b1, 50);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        hold(1'b1, 50);
        send_frame(8'h03, 1'b1, 1'b0);
        hold(1'b1, 50);
`endif

        // Short low glitch on an idle line.
        last_busy_len = -1;
        hold(1'b0, 100);
        hold(1'b1, 2 * c_BAUD);
        check("glitch_busy_len", last_busy_len >= c_HALF - 3 && last_busy_len <= c_HALF + 3,
              32'(last_busy_len), 32'(c_HALF));
        check("glitch_data_kept", data == last_good, 32'(data), 32'(last_good));

        // Stop bit low, then line held low (break).
        send_frame(8'hA5, 1'b0, good_par(8'hA5));
        hold(1'b0, 3 * c_BAUD);
        check("break_no_restart", rx_busy == 1'b0, 32'(rx_busy), 32'd0);
        hold(1'b1, c_BAUD);

        // Reset during data bit 4 of a frame that is never reported.
        d = 8'hE7;
        hold(1'b0, c_BAUD);
        for (int i = 0; i < 4; i++) hold(d[i], c_BAUD);
        hold(d[4], c_BAUD / 2);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("midframe_reset", {data, data_valid, rx_busy, frame_err, perr} == '0,
              32'({data, data_valid, rx_busy, frame_err, perr}), 32'd0);
        last_good = '0;
        rst = 1'b0;
        hold(1'b1, 2 * c_BAUD);
        send_frame(8'h3C, 1'b1, good_par(8'h3C));
        hold(1'b1, 50);

        // Randomized frames.
        for (int k = 0; k < 5; k++) begin
            d  = c_W'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            pb = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            send_frame(d, sb, pb);
            if (!sb) hold(1'b1, c_BAUD);
            hold(1'b1, $urandom_range(0, 40));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 2 * c_BAUD) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        hold(1'b1, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
